// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage MIPS core: load-use stalls, branch
// squash, precise exception sequencing and ERET return.
module pipe_hazard_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_0080,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             Branch_Taken,
  input  logic             Illegal_op_excep,
  input  logic             Overflow_excep,
  input  logic [31:0]      ID_PCPlus4,
  input  logic [31:0]      EX_PCPlus4,
  input  logic             Eret,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush_excep,
  output logic             EX_MEM_Flush,
  output logic [1:0]       PC_Sel,
  output logic [31:0]      EPC,
  output logic [1:0]       Cause,
  output logic             Excep_Active,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    VECTOR  = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             stall_ev;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == ID_Rs) || (IDEX_Rt == ID_Rt));

  // Next-state, exception capture and combinational pipeline controls.
  always_comb begin
    state_d           = state_q;
    epc_d             = epc_q;
    cause_d           = cause_q;
    stall_ev          = 1'b0;
    PC_Write          = 1'b1;
    IF_ID_Write       = 1'b1;
    IF_ID_Flush       = 1'b0;
    ID_EX_Flush_excep = 1'b0;
    EX_MEM_Flush      = 1'b0;
    PC_Sel            = 2'b00;
    unique case (state_q)
      RUN: begin
        if (Overflow_excep) begin
          PC_Write          = 1'b0;
          IF_ID_Flush       = 1'b1;
          ID_EX_Flush_excep = 1'b1;
          EX_MEM_Flush      = 1'b1;
          epc_d             = EX_PCPlus4 - 32'd4;
          cause_d           = 2'b10;
          state_d           = VECTOR;
        end else if (Illegal_op_excep) begin
          PC_Write          = 1'b0;
          IF_ID_Flush       = 1'b1;
          ID_EX_Flush_excep = 1'b1;
          epc_d             = ID_PCPlus4 - 32'd4;
          cause_d           = 2'b01;
          state_d           = VECTOR;
        end else if (load_use) begin
          stall_ev          = 1'b1;
          PC_Write          = 1'b0;
          IF_ID_Write       = 1'b0;
          ID_EX_Flush_excep = 1'b1;
        end else if (Branch_Taken) begin
          PC_Sel      = 2'b01;
          IF_ID_Flush = 1'b1;
        end
      end
      VECTOR: begin
        PC_Sel            = 2'b10;
        IF_ID_Flush       = 1'b1;
        ID_EX_Flush_excep = 1'b1;
        state_d           = HANDLER;
      end
      HANDLER: begin
        // Exception inputs are masked while the handler runs.
        if (load_use) begin
          stall_ev          = 1'b1;
          PC_Write          = 1'b0;
          IF_ID_Write       = 1'b0;
          ID_EX_Flush_excep = 1'b1;
        end else if (Eret) begin
          PC_Sel      = 2'b11;
          IF_ID_Flush = 1'b1;
          state_d     = RUN;
        end else if (Branch_Taken) begin
          PC_Sel      = 2'b01;
          IF_ID_Flush = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      stall_ev          = 1'b0;
      PC_Write          = 1'b0;
      IF_ID_Write       = 1'b0;
      IF_ID_Flush       = 1'b1;
      ID_EX_Flush_excep = 1'b1;
      EX_MEM_Flush      = 1'b1;
      PC_Sel            = 2'b00;
    end
  end

  // Saturating event counters; reset-cycle flushes are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (!reset && IF_ID_Flush && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State, EPC/Cause and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      epc_q       <= '0;
      cause_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign EPC          = epc_q;
  assign Cause        = cause_q;
  assign Stall_Cnt    = stall_cnt_q;
  assign Flush_Cnt    = flush_cnt_q;
  assign Excep_Active = (state_q == VECTOR) || (state_q == HANDLER);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Inputs change 1ns after posedge; outputs are sampled mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, IDEX_Rt;
  logic        IDEX_MemRead, Branch_Taken;
  logic        Illegal_op_excep, Overflow_excep, Eret;
  logic [31:0] ID_PCPlus4, EX_PCPlus4;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush;
  logic        ID_EX_Flush_excep, EX_MEM_Flush;
  logic [1:0]  PC_Sel, Cause;
  logic [31:0] EPC;
  logic        Excep_Active;
  logic [15:0] Stall_Cnt, Flush_Cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .Branch_Taken(Branch_Taken),
    .Illegal_op_excep(Illegal_op_excep),
    .Overflow_excep(Overflow_excep),
    .ID_PCPlus4(ID_PCPlus4), .EX_PCPlus4(EX_PCPlus4),
    .Eret(Eret),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush_excep(ID_EX_Flush_excep),
    .EX_MEM_Flush(EX_MEM_Flush), .PC_Sel(PC_Sel),
    .EPC(EPC), .Cause(Cause), .Excep_Active(Excep_Active),
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ID_Rs = 0; ID_Rt = 0; IDEX_Rt = 0;
    IDEX_MemRead = 0; Branch_Taken = 0;
    Illegal_op_excep = 0; Overflow_excep = 0; Eret = 0;
    ID_PCPlus4 = 0; EX_PCPlus4 = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1;
    tick();
    #2;
    total_cnt++;
    if ({PC_Write, IF_ID_Write} !== 2'b00) $display("FAIL rst_we got %b want 00", {PC_Write, IF_ID_Write});
    else pass_cnt++;
    total_cnt++;
    if ({IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush} !== 3'b111)
      $display("FAIL rst_flush got %b want 111", {IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush});
    else pass_cnt++;
    total_cnt++;
    if (PC_Sel !== 2'b00) $display("FAIL rst_sel got %b want 00", PC_Sel);
    else pass_cnt++;
    tick();
    reset = 0;
    #2;
    total_cnt++;
    if ({EPC, Cause, Stall_Cnt, Flush_Cnt} !== 66'd0)
      $display("FAIL rst_regs got %h/%b/%h/%h want 0", EPC, Cause, Stall_Cnt, Flush_Cnt);
    else pass_cnt++;
    total_cnt++;
    if ({Excep_Active, PC_Write, IF_ID_Write, PC_Sel} !== 5'b01100)
      $display("FAIL run_default got %b want 01100", {Excep_Active, PC_Write, IF_ID_Write, PC_Sel});
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_MemRead = 1; IDEX_Rt = 8; ID_Rs = 8;
    #2;
    total_cnt++;
    if ({PC_Write, IF_ID_Write, ID_EX_Flush_excep, IF_ID_Flush} !== 4'b0010)
      $display("FAIL lu_stall got %b want 0010", {PC_Write, IF_ID_Write, ID_EX_Flush_excep, IF_ID_Flush});
    else pass_cnt++;
    tick();
    clear_in();
    #2;
    total_cnt++;
    if (Stall_Cnt !== 16'd1) $display("FAIL lu_cnt got %0d want 1", Stall_Cnt);
    else pass_cnt++;
    total_cnt++;
    if ({PC_Write, IF_ID_Write, ID_EX_Flush_excep} !== 3'b110)
      $display("FAIL lu_clear got %b want 110", {PC_Write, IF_ID_Write, ID_EX_Flush_excep});
    else pass_cnt++;
    IDEX_MemRead = 1; IDEX_Rt = 0; ID_Rs = 0;
    #2;
    total_cnt++;
    if ({PC_Write, IF_ID_Write, ID_EX_Flush_excep} !== 3'b110)
      $display("FAIL lu_r0 got %b want 110", {PC_Write, IF_ID_Write, ID_EX_Flush_excep});
    else pass_cnt++;
    tick();
    IDEX_Rt = 5'd17; ID_Rs = 5'd3; ID_Rt = 5'd17;
    #2;
    total_cnt++;
    if ({PC_Write, ID_EX_Flush_excep} !== 2'b01)
      $display("FAIL lu_rt got %b want 01", {PC_Write, ID_EX_Flush_excep});
    else pass_cnt++;
    tick();
    clear_in();
    #2;
    total_cnt++;
    if (Stall_Cnt !== 16'd2) $display("FAIL lu_cnt2 got %0d want 2", Stall_Cnt);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset();
    Branch_Taken = 1;
    #2;
    total_cnt++;
    if ({PC_Sel, IF_ID_Flush, PC_Write} !== 4'b0111)
      $display("FAIL br_taken got %b want 0111", {PC_Sel, IF_ID_Flush, PC_Write});
    else pass_cnt++;
    tick();
    IDEX_MemRead = 1; IDEX_Rt = 9; ID_Rt = 9;
    #2;
    total_cnt++;
    if (Flush_Cnt !== 16'd1) $display("FAIL br_fcnt got %0d want 1", Flush_Cnt);
    else pass_cnt++;
    total_cnt++;
    if ({PC_Sel, IF_ID_Flush, PC_Write, IF_ID_Write} !== 5'b00000)
      $display("FAIL br_stall got %b want 00000", {PC_Sel, IF_ID_Flush, PC_Write, IF_ID_Write});
    else pass_cnt++;
    tick();
    IDEX_MemRead = 0;
    #2;
    total_cnt++;
    if ({Flush_Cnt, Stall_Cnt, PC_Sel} !== {16'd1, 16'd1, 2'b01})
      $display("FAIL br_retry got %0d/%0d/%b want 1/1/01", Flush_Cnt, Stall_Cnt, PC_Sel);
    else pass_cnt++;
    tick();
    clear_in();
  endtask

  task automatic test_overflow();
    do_reset();
    Overflow_excep = 1; EX_PCPlus4 = 32'h40;
    Branch_Taken = 1; IDEX_MemRead = 1; IDEX_Rt = 4; ID_Rs = 4;
    #2;
    total_cnt++;
    if ({IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Write, PC_Sel} !== 6'b111000)
      $display("FAIL ovf_T got %b want 111000",
               {IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Write, PC_Sel});
    else pass_cnt++;
    tick();
    clear_in();
    #2;
    total_cnt++;
    if ({EPC, Cause, Excep_Active} !== {32'h3C, 2'b10, 1'b1})
      $display("FAIL ovf_epc got %h/%b/%b want 3c/10/1", EPC, Cause, Excep_Active);
    else pass_cnt++;
    total_cnt++;
    if ({PC_Sel, PC_Write, IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush} !== 6'b101110)
      $display("FAIL ovf_vec got %b want 101110",
               {PC_Sel, PC_Write, IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush});
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if ({Excep_Active, PC_Sel, IF_ID_Flush, Flush_Cnt, Stall_Cnt} !== {1'b1, 2'b00, 1'b0, 16'd2, 16'd0})
      $display("FAIL ovf_hdl got %b/%b/%b/%0d/%0d want 1/00/0/2/0",
               Excep_Active, PC_Sel, IF_ID_Flush, Flush_Cnt, Stall_Cnt);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    do_reset();
    Illegal_op_excep = 1; ID_PCPlus4 = 32'h104; EX_PCPlus4 = 32'h200;
    #2;
    total_cnt++;
    if ({IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Write} !== 4'b1100)
      $display("FAIL ill_T got %b want 1100", {IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Write});
    else pass_cnt++;
    tick();
    clear_in();
    #2;
    total_cnt++;
    if ({EPC, Cause, PC_Sel} !== {32'h100, 2'b01, 2'b10})
      $display("FAIL ill_epc got %h/%b/%b want 100/01/10", EPC, Cause, PC_Sel);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    Overflow_excep = 1; Illegal_op_excep = 1;
    EX_PCPlus4 = 32'h20; ID_PCPlus4 = 32'h24;
    tick();
    clear_in();
    #2;
    total_cnt++;
    if ({EPC, Cause} !== {32'h1C, 2'b10})
      $display("FAIL sim_epc got %h/%b want 1c/10", EPC, Cause);
    else pass_cnt++;
    Overflow_excep = 1; EX_PCPlus4 = 32'h80;
    tick();
    #2;
    total_cnt++;
    if ({EPC, Cause, PC_Sel} !== {32'h1C, 2'b10, 2'b01} && 1'b0) pass_cnt = pass_cnt;
    total_cnt--;
    total_cnt++;
    if ({IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Write} !== 4'b0001)
      $display("FAIL hdl_mask got %b want 0001", {IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Write});
    else pass_cnt++;
    tick();
    Overflow_excep = 0; Illegal_op_excep = 1; ID_PCPlus4 = 32'h300;
    #2;
    total_cnt++;
    if ({EPC, Cause, Excep_Active, PC_Sel} !== {32'h1C, 2'b10, 1'b1, 2'b00})
      $display("FAIL hdl_drop got %h/%b/%b/%b want 1c/10/1/00", EPC, Cause, Excep_Active, PC_Sel);
    else pass_cnt++;
    tick();
    clear_in();
  endtask

  task automatic test_eret();
    Eret = 1; IDEX_MemRead = 1; IDEX_Rt = 6; ID_Rs = 6;
    #2;
    total_cnt++;
    if ({PC_Sel, PC_Write, ID_EX_Flush_excep, IF_ID_Flush} !== 5'b00010)
      $display("FAIL eret_hold got %b want 00010", {PC_Sel, PC_Write, ID_EX_Flush_excep, IF_ID_Flush});
    else pass_cnt++;
    tick();
    IDEX_MemRead = 0;
    #2;
    total_cnt++;
    if ({Excep_Active, PC_Sel, IF_ID_Flush} !== 4'b1111)
      $display("FAIL eret_go got %b want 1111", {Excep_Active, PC_Sel, IF_ID_Flush});
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if ({Excep_Active, PC_Sel, IF_ID_Flush, EPC} !== {1'b0, 2'b00, 1'b0, 32'h1C})
      $display("FAIL eret_run got %b/%b/%b/%h want 0/00/0/1c", Excep_Active, PC_Sel, IF_ID_Flush, EPC);
    else pass_cnt++;
    tick();
    clear_in();
  endtask

  task automatic test_reset_mid();
    do_reset();
    Overflow_excep = 1; EX_PCPlus4 = 32'h50;
    tick();
    clear_in();
    reset = 1;
    #2;
    total_cnt++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Sel} !== 7'b0011100)
      $display("FAIL midrst_force got %b want 0011100",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush_excep, EX_MEM_Flush, PC_Sel});
    else pass_cnt++;
    tick();
    reset = 0;
    #2;
    total_cnt++;
    if ({Excep_Active, EPC, Cause, Stall_Cnt, Flush_Cnt, PC_Sel} !== 69'd0)
      $display("FAIL midrst_run got %b/%h/%b/%0d/%0d/%b want all 0",
               Excep_Active, EPC, Cause, Stall_Cnt, Flush_Cnt, PC_Sel);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    do_reset();
    IDEX_MemRead = 1; IDEX_Rt = 2; ID_Rs = 2;
    repeat (65534) tick();
    total_cnt++;
    if (Stall_Cnt !== 16'hFFFE) $display("FAIL sat_pre got %h want fffe", Stall_Cnt);
    else pass_cnt++;
    repeat (4466) tick();
    total_cnt++;
    if (Stall_Cnt !== 16'hFFFF) $display("FAIL sat_max got %h want ffff", Stall_Cnt);
    else pass_cnt++;
    clear_in();
  endtask

  initial begin
    reset = 1;
    clear_in();
    test_reset();
    test_load_use();
    test_branch();
    test_overflow();
    test_illegal();
    test_simultaneous();
    test_eret();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage MIPS core. It drives the IF/ID, ID/EX and EX/MEM write-enable and flush controls and the PC source select. It detects load-use hazards and inserts one bubble per stall cycle, and it squashes wrong-path instructions on taken branches. It sequences precise exceptions: squash, capture EPC/Cause, vector to the handler, and return on ERET. It sits beside the hazard/forwarding logic and feeds the `ID_EX_Flush_excep` input of the ID/EX register directly.

## Interface
Parameters:
- `HANDLER_PC`, 32'h0000_0080, exception vector address; the PC mux uses it when `PC_Sel`=2'b10.
- `CNT_W`, 16, width of the saturating performance counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `ID_Rs`, `ID_Rt`  in  5  source registers of the instruction in ID.
- `IDEX_MemRead`  in  1  the instruction in EX is a load.
- `IDEX_Rt`  in  5  destination of the instruction in EX.
- `Branch_Taken`  in  1  branch resolved taken in ID.
- `Illegal_op_excep`  in  1  undefined opcode decoded in ID.
- `Overflow_excep`  in  1  arithmetic overflow in EX.
- `ID_PCPlus4`, `EX_PCPlus4`  in  32  PC+4 of the ID-stage and EX-stage instructions.
- `Eret`  in  1  return-from-exception decoded in ID.
- `PC_Write`  out  1  PC register enable.
- `IF_ID_Write`  out  1  IF/ID enable.
- `IF_ID_Flush`  out  1  zero the IF/ID instruction.
- `ID_EX_Flush_excep`  out  1  bubble into ID/EX.
- `EX_MEM_Flush`  out  1  zero the EX/MEM control fields.
- `PC_Sel`  out  2  00 PC+4, 01 branch target, 10 `HANDLER_PC`, 11 `EPC`.
- `EPC`  out  32  faulting instruction address (registered).
- `Cause`  out  2  01 illegal opcode, 10 overflow (registered).
- `Excep_Active`  out  1  high in VECTOR and HANDLER.
- `Stall_Cnt`, `Flush_Cnt`  out  `CNT_W`  saturating event counters.

## Operation
- The FSM has three states: RUN, VECTOR and HANDLER.
- Outputs are combinational from the state and the inputs. State, `EPC`, `Cause` and the counters are registers.
- While `reset`=1, outputs are forced to: `PC_Write`=0, `IF_ID_Write`=0, all three flushes=1, `PC_Sel`=00.
- On the reset edge: state goes to RUN; `EPC`, `Cause`, `Stall_Cnt` and `Flush_Cnt` go to 0.
- Default outputs in RUN: `PC_Write`=1, `IF_ID_Write`=1, flushes=0, `PC_Sel`=00.
- Priority in RUN, highest first: `Overflow_excep` > `Illegal_op_excep` > load-use stall > `Branch_Taken`.
- Exception in RUN:
  - Same cycle: `IF_ID_Flush`, `ID_EX_Flush_excep` and `EX_MEM_Flush` are all 1, and `PC_Write`=0.
  - Overflow: at the edge, `EPC`<=`EX_PCPlus4`-4 and `Cause`<=2'b10.
  - Illegal opcode only: `EX_MEM_Flush`=0, `EPC`<=`ID_PCPlus4`-4, `Cause`<=01.
  - The FSM goes to VECTOR.
- Load-use stall condition: `IDEX_MemRead` && `IDEX_Rt`!=0 && (`IDEX_Rt`==`ID_Rs` || `IDEX_Rt`==`ID_Rt`).
  - Response: `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush_excep`=1.
  - A `Branch_Taken` asserted in the same cycle is ignored; it is re-evaluated once the stall clears.
- Taken branch, no stall: `PC_Sel`=01 and `IF_ID_Flush`=1.
- VECTOR (always one cycle): `PC_Sel`=10, `PC_Write`=1, `IF_ID_Flush`=1, `ID_EX_Flush_excep`=1. Next state is HANDLER.
- HANDLER:
  - Normal RUN behaviour (stalls, branches), except exception inputs are ignored (masked).
  - `Eret` with no stall: `PC_Sel`=11, `IF_ID_Flush`=1, next state RUN.
  - `Eret` during a stall: held off until the stall clears.
- `Stall_Cnt` increments on every stall cycle. `Flush_Cnt` increments on every cycle with `IF_ID_Flush`=1 outside reset. Both saturate at all-ones.
- `EPC` and `Cause` hold their values until the next accepted exception.

## Timing
- Flush and stall responses have 0-cycle latency: they are combinational in the detection cycle and take effect at the next edge.
- Exception to handler fetch: detection cycle T squashes, VECTOR at T+1 loads `HANDLER_PC`, and the handler instruction reaches IF/ID at T+2.
- `EPC`, `Cause` and `Excep_Active` are valid from T+1.
- A load-use pair costs exactly one bubble. A taken branch costs one squashed fetch.
- Boundary cases:
  - `IDEX_Rt`=0 never stalls.
  - Both exceptions in the same cycle record Overflow only.
  - An exception arriving in VECTOR or HANDLER is dropped with no state change.
  - `Eret` in RUN is ignored.
  - `reset` asserted in VECTOR or HANDLER returns the FSM to RUN on that edge.

## Test plan
- Load-use: `IDEX_MemRead`=1, `IDEX_Rt`=8, `ID_Rs`=8 for one cycle -> `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush_excep`=1 for that cycle; `Stall_Cnt`=1. Repeat with `IDEX_Rt`=0 -> no stall.
- Branch: `Branch_Taken`=1 with no hazard -> `PC_Sel`=01, `IF_ID_Flush`=1; `Flush_Cnt`=1. Branch together with a load-use hazard -> stall only, `PC_Sel`=00.
- Overflow: `Overflow_excep`=1, `EX_PCPlus4`=32'h40 -> all flushes=1 that cycle; next cycle VECTOR with `PC_Sel`=10, `EPC`=32'h3C, `Cause`=10, `Excep_Active`=1.
- Simultaneous exceptions: Overflow + Illegal, `EX_PCPlus4`=32'h20, `ID_PCPlus4`=32'h24 -> `EPC`=32'h1C, `Cause`=10. A second `Overflow_excep` in HANDLER -> `EPC` unchanged.
- Return: in HANDLER, `Eret`=1 -> `PC_Sel`=11, `IF_ID_Flush`=1, next state RUN, `Excep_Active`=0. `Eret` coincident with a stall -> deferred one cycle.
- Reset mid-operation: `reset`=1 during VECTOR -> next cycle RUN with `EPC`=0, `Cause`=0, counters=0. Drive 70000 stall cycles -> `Stall_Cnt` saturates at 16'hFFFF.
